// File: rtl/entry_pkg.sv
// Shared types and defaults for the operand-entry capture block.
package entry_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2
    } deb_state_t;

    localparam int DEBOUNCE_DEFAULT   = 500000;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Level the debouncer is currently waiting to see held on the synchronised button.
    function automatic logic deb_target_level(input deb_state_t st);
        logic lvl;
        case (st)
            INIT:    lvl = 1'b1;
            IDLE:    lvl = 1'b0;
            PRESSED: lvl = 1'b1;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counting debounce FSM for the active-low enter button.
// Emits a single-cycle press_pulse on the edge that validates a press.
module button_debounce
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic nreset,
    input  logic nenter,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             s_n_q;
    deb_state_t       state_q;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_s;

    // Synchroniser, counter and state registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1_q <= 1'b1;
            s_n_q   <= 1'b1;
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            sync1_q <= nenter;
            s_n_q   <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: the count restarts on any mismatch and on every state change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        level_s     = deb_target_level(state_q);
        if (s_n_q != level_s) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
                INIT: begin
                    state_d = IDLE;
                end
                IDLE: begin
                    state_d     = PRESSED;
                    press_pulse = 1'b1;
                end
                PRESSED: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/entry_capture.sv
// Captures the switch byte on each debounced press into a small FIFO and offers
// the oldest entry to the control unit through a ready/load handshake.
module entry_capture
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DEPTH           = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     nenter,
    input  logic [7:0]               inputdata,
    input  logic                     loaddata,
    output logic                     inputdata_ready,
    output logic [7:0]               dataout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             press_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .nreset      (nreset),
        .nenter      (nenter),
        .press_pulse (press_s)
    );

    assign full_s = (count_q == DEPTH_C);

    // Push/pop arbitration; a pop in the same edge frees the slot for a push when full.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop_s      = loaddata && (count_q != '0);
        push_s     = press_s && (!full_s || pop_s);
        if (press_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= inputdata;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign inputdata_ready = (count_q != '0);
    assign dataout         = mem_q[rd_ptr_q];
    assign count           = count_q;
    assign full            = full_s;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_entry_capture.sv
// Directed bench for entry_capture with a short debounce window and a 4-deep FIFO.
module tb_entry_capture;

    logic       clk;
    logic       nreset;
    logic       nenter;
    logic [7:0] inputdata;
    logic       loaddata;
    logic       inputdata_ready;
    logic [7:0] dataout;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int n_total;
    int n_bad;

    entry_capture #(
        .DEBOUNCE_CYCLES (4),
        .DEPTH           (4)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .nenter          (nenter),
        .inputdata       (inputdata),
        .loaddata        (loaddata),
        .inputdata_ready (inputdata_ready),
        .dataout         (dataout),
        .count           (count),
        .full            (full),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] d);
        inputdata = d;
        nenter = 1'b0;
        tick(6);
        nenter = 1'b1;
        tick(7);
    endtask

    task automatic pop();
        loaddata = 1'b1;
        tick(1);
        loaddata = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick(1);
        nreset = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [7:0] bounce [6];
        n_total   = 0;
        n_bad     = 0;
        nreset    = 1'b0;
        nenter    = 1'b1;
        inputdata = 8'h00;
        loaddata  = 1'b0;
        tick(2);
        check("rst_ready", 32'(inputdata_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dout", 32'(dataout), 32'h00);
        nreset = 1'b1;
        tick(6);

        // 1: push latency and single push per press
        inputdata = 8'h3C;
        nenter = 1'b0;
        tick(5);
        check("t1_not_yet", 32'(inputdata_ready), 32'd0);
        tick(1);
        check("t1_ready", 32'(inputdata_ready), 32'd1);
        check("t1_dout", 32'(dataout), 32'h3C);
        check("t1_count", 32'(count), 32'd1);
        tick(14);
        check("t1_hold", 32'(count), 32'd1);
        nenter = 1'b1;
        tick(3);
        nenter = 1'b0;
        tick(10);
        check("t1_short_rel", 32'(count), 32'd1);
        nenter = 1'b1;
        tick(7);
        press(8'h77);
        check("t1_second", 32'(count), 32'd2);
        check("t1_head", 32'(dataout), 32'h3C);
        pop();
        check("t1_pop1", 32'(dataout), 32'h77);
        pop();
        check("t1_empty", 32'(inputdata_ready), 32'd0);

        // 2: bounce rejection then clean press
        bounce[0] = 8'd0; bounce[1] = 8'd0; bounce[2] = 8'd1;
        bounce[3] = 8'd0; bounce[4] = 8'd0; bounce[5] = 8'd1;
        inputdata = 8'h99;
        for (int i = 0; i < 6; i++) begin
            nenter = bounce[i][0];
            tick(1);
        end
        nenter = 1'b1;
        tick(8);
        check("t2_bounce", 32'(count), 32'd0);
        press(8'h5A);
        check("t2_clean", 32'(count), 32'd1);
        check("t2_dout", 32'(dataout), 32'h5A);
        pop();

        // 3: fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) press(8'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        check("t3_head", 32'(dataout), 32'h01);
        check("t3_no_ovf", 32'(overflow), 32'd0);
        press(8'h05);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_cnt_ovf", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", 32'(dataout), 32'(i));
            pop();
        end
        check("t3_drained", 32'(inputdata_ready), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        pop();
        check("t3_pop_empty", 32'(count), 32'd0);

        // 4: interleaved traffic across pointer wrap
        press(8'hA0);
        for (int i = 1; i < 10; i++) begin
            press(8'hA0 + 8'(i));
            check("t4_cnt2", 32'(count), 32'd2);
            check("t4_order", 32'(dataout), 32'(8'hA0 + 8'(i - 1)));
            pop();
            check("t4_cnt1", 32'(count), 32'd1);
        end
        check("t4_last", 32'(dataout), 32'hA9);
        pop();
        check("t4_empty", 32'(inputdata_ready), 32'd0);

        // 5: push and pop in the same edge while full
        do_reset();
        for (int i = 0; i < 4; i++) press(8'h11 + 8'(i));
        inputdata = 8'h55;
        nenter = 1'b0;
        tick(5);
        check("t5_pre", 32'(count), 32'd4);
        loaddata = 1'b1;
        tick(1);
        loaddata = 1'b0;
        check("t5_count", 32'(count), 32'd4);
        check("t5_head", 32'(dataout), 32'h12);
        check("t5_ovf", 32'(overflow), 32'd0);
        nenter = 1'b1;
        tick(7);
        pop(); pop(); pop();
        check("t5_tail", 32'(dataout), 32'h55);
        pop();
        check("t5_empty", 32'(inputdata_ready), 32'd0);

        // 6: reset while holding the button with data stored
        for (int i = 0; i < 4; i++) press(8'h21 + 8'(i));
        press(8'h25);
        pop();
        check("t6_pre_cnt", 32'(count), 32'd3);
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        nenter = 1'b0;
        tick(3);
        nreset = 1'b0;
        tick(1);
        nreset = 1'b1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_ready", 32'(inputdata_ready), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_dout", 32'(dataout), 32'h00);
        tick(12);
        check("t6_held", 32'(count), 32'd0);
        nenter = 1'b1;
        tick(3);
        nenter = 1'b0;
        tick(10);
        check("t6_short_rel", 32'(count), 32'd0);
        nenter = 1'b1;
        tick(7);
        press(8'h66);
        check("t6_repress", 32'(count), 32'd1);
        check("t6_repress_d", 32'(dataout), 32'h66);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/entry_capture.md
Name: entry_capture

Overview:
- Producer side of the operand-entry handshake.
- Synchronises and debounces the active-low `nenter` pushbutton. On each validated press, captures the 8-bit switch value `inputdata` into a small FIFO.
- Offers the oldest entry through `inputdata_ready` / `loaddata` to the control unit and datapath, which consume one byte per accepted handshake.
- Sits between the board switches/button and the existing control unit.

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive synchronised samples at one level required to validate a press or a release. This is 10 ms at 50 MHz. Must be ≥2.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `nreset`  in  1  synchronous, active-low reset.
- `nenter`  in  1  raw pushbutton, active low, asynchronous to `clk`.
- `inputdata`  in  8  switch value, static while the button is held.
- `loaddata`  in  1  consumer accepts the head entry this cycle.
- `inputdata_ready`  out  1  FIFO not empty; `dataout` is valid.
- `dataout`  out  8  head-of-FIFO byte.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `full`  out  1  `count` == DEPTH.
- `overflow`  out  1  sticky flag: a press was dropped because the FIFO was full.

Behaviour:
- **Reset** (`nreset`=0 sampled at an edge):
  - Both synchroniser flops go to 1.
  - Debounce counter goes to 0 and the FSM goes to INIT.
  - FIFO pointers and `count` go to 0.
  - `inputdata_ready`=0, `full`=0, `overflow`=0, `dataout`=8'h00.
  - Reset mid-press or mid-handshake discards all stored data.
- **Synchroniser:** two flops on `nenter`; `s_n` is the second stage. This adds 2 edges of latency.
- **FSM** (the debounce counter clears on every state change and whenever `s_n` differs from the level being counted):
  - INIT: count edges with `s_n`=1. After DEBOUNCE_CYCLES consecutive edges, go to IDLE. A button held through reset is therefore never captured.
  - IDLE: count edges with `s_n`=0. On the DEBOUNCE_CYCLES-th consecutive edge, go to PRESSED and issue one push strobe in that same edge.
  - PRESSED: count edges with `s_n`=1. After DEBOUNCE_CYCLES consecutive edges, go to IDLE. Exactly one push is issued per press, regardless of hold time.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count and has no other effect.
- **Push latency:** let edge 0 be the first edge that samples `nenter`=0. The push is written at edge DEBOUNCE_CYCLES+1, and `inputdata_ready` is high immediately after that edge. `inputdata` is sampled at the push edge.
- **Pop:**
  - `loaddata` && `inputdata_ready` at an edge removes the head entry. `dataout` shows the next entry after that edge.
  - `loaddata` while empty is ignored.
- **`dataout`:** driven from registered FIFO storage addressed by the read pointer. It is combinational from registers and holds its last value when the FIFO is empty.
- **Simultaneous push and pop:**
  - Both take effect and `count` is unchanged. This also holds when full: the pop frees the slot.
  - When empty, the push is stored and the pop is ignored because `inputdata_ready` was 0.
- **Push while full without pop:** the byte is dropped, `count` stays DEPTH, and `overflow` is set. `overflow` clears only on reset.
- **Pointers:** $clog2(DEPTH) bits each, wrapping modulo DEPTH. `count` is updated +1, −1 or 0 in the same edge as the pointers.

Decomposition:
- Package `entry_pkg`:
  - `typedef enum logic [1:0] {INIT, IDLE, PRESSED} deb_state_t`
  - `localparam DEBOUNCE_DEFAULT = 500000`
  - `localparam FIFO_DEPTH_DEFAULT = 4`
- Sub-module `button_debounce`:
  - Contains the synchroniser, counter and FSM.
  - Ports: `clk`, `nreset`, `nenter` → `press_pulse`.
  - `entry_capture` instantiates it and holds the FIFO and handshake logic.

Test Plan (bench uses DEBOUNCE_CYCLES=4, DEPTH=4, 20 ns clock):
1. Release reset with `nenter`=1, then hold `nenter`=0 with `inputdata`=8'h3C for 20 cycles → `inputdata_ready` rises right after edge 5; `dataout`=8'h3C; `count`=1. A second push occurs only after release plus 4 high edges and a new press.
2. Bounce: `nenter` pattern 0,0,1,0,0,1 and then high → no push; `count` stays 0. A clean 6-cycle low then pushes once.
3. Fill: presses with 8'h01, 02, 03, 04 → `full`=1, `count`=4, `dataout`=8'h01. Fifth press with 8'h05 → `overflow`=1, `count`=4. Popping all entries returns 01, 02, 03, 04 in order, then `inputdata_ready`=0.
4. Wrap-around: push/pop 10 bytes 8'hA0..A9 interleaved → order is preserved across pointer wrap; `count` never exceeds 2.
5. Simultaneous: with `full`=1, hold `loaddata`=1 on the push edge of 8'h55 → `count` stays 4, head advances, 8'h55 is stored last, `overflow` stays 0.
6. Reset mid-operation: with 3 entries stored and the button held, assert `nreset`=0 for 1 edge → `count`=0, `inputdata_ready`=0, `overflow`=0. The still-held button produces no push until it has been released for 4 edges and pressed again.
